// File: rtl/tick_gen_pkg.sv
// Shared tick generator settings: default channel count and field widths, the system
// clock rate, and per-channel default divisors for the PLL, RTC and UART rates.
package tick_gen_pkg;

  localparam int CLK_FREQ_HZ   = 50_000_000;
  localparam int TICK_CHANNELS = 3;
  localparam int TICK_CNT_W    = 16;
  localparam int TICK_FRAC_W   = 8;

  typedef struct packed {
    logic                   en;
    logic [TICK_CNT_W-1:0]  div_int;
    logic [TICK_FRAC_W-1:0] div_frac;
  } tick_cfg_t;

  // Divisor N for a tick rate: the period N+1 cycles is the clock rate over the tick rate.
  function automatic logic [TICK_CNT_W-1:0] tick_div(input int freq, input int rate);
    return TICK_CNT_W'(freq / rate - 1);
  endfunction

  localparam logic [TICK_CNT_W-1:0] TICK_DEFAULT_INT [TICK_CHANNELS] = '{
    tick_div(CLK_FREQ_HZ, 1_000_000),
    tick_div(CLK_FREQ_HZ, 32_768),
    tick_div(CLK_FREQ_HZ, 115_200)
  };

endpackage

// File: rtl/tick_gen_chan.sv
// One tick channel: down-counter, optional fractional accumulator (TICK_GEN_FRAC_EN),
// and a shadow divisor that a running channel picks up at its next terminal count.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int CNT_WIDTH  = TICK_CNT_W,
  parameter int FRAC_WIDTH = TICK_FRAC_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_i,
  input  logic                  en_i,
  input  logic [CNT_WIDTH-1:0]  int_i,
  input  logic [FRAC_WIDTH-1:0] frac_i,
  output logic                  pend_o,
  output logic                  tick_o,
  output logic                  toggle_o
);

  logic                 en_q, en_d;
  logic [CNT_WIDTH-1:0] int_q, int_d;
  logic [CNT_WIDTH-1:0] sh_int_q, sh_int_d;
  logic [CNT_WIDTH:0]   cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 tick_q, tick_d;
  logic                 tog_q, tog_d;
  logic                 carry;
  logic                 tc;

  assign tc = en_q && (cnt_q == '0);

`ifdef TICK_GEN_FRAC_EN
  logic [FRAC_WIDTH-1:0] frac_q, frac_d;
  logic [FRAC_WIDTH-1:0] sh_frac_q, sh_frac_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [FRAC_WIDTH:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, frac_q};
  assign carry = sum[FRAC_WIDTH];
`else
  logic unused_frac;

  assign unused_frac = ^frac_i;
  assign carry       = 1'b0;
`endif

  always_comb begin
    en_d     = en_q;
    int_d    = int_q;
    sh_int_d = sh_int_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    tog_d    = tog_q;
`ifdef TICK_GEN_FRAC_EN
    frac_d    = frac_q;
    sh_frac_d = sh_frac_q;
    acc_d     = acc_q;
`endif
    if (tc) begin
      tick_d = 1'b1;
      tog_d  = ~tog_q;
      if (pend_q) begin
        pend_d = 1'b0;
        int_d  = sh_int_q;
        cnt_d  = {1'b0, sh_int_q};
`ifdef TICK_GEN_FRAC_EN
        frac_d = sh_frac_q;
        acc_d  = '0;
`endif
      end else begin
        cnt_d = {1'b0, int_q} + {{CNT_WIDTH{1'b0}}, carry};
`ifdef TICK_GEN_FRAC_EN
        acc_d = sum[FRAC_WIDTH-1:0];
`endif
      end
    end else if (en_q) begin
      cnt_d = cnt_q - {{CNT_WIDTH{1'b0}}, 1'b1};
    end
    // A write to an idle channel, or any disable, takes effect now and restarts the phase.
    if (wr_i) begin
      if (!en_q || !en_i) begin
        en_d   = en_i;
        int_d  = int_i;
        cnt_d  = {1'b0, int_i};
        pend_d = 1'b0;
        tick_d = 1'b0;
        tog_d  = 1'b0;
`ifdef TICK_GEN_FRAC_EN
        frac_d = frac_i;
        acc_d  = '0;
`endif
      end else begin
        sh_int_d = int_i;
        pend_d   = 1'b1;
`ifdef TICK_GEN_FRAC_EN
        sh_frac_d = frac_i;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q   <= 1'b0;
      int_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      tog_q  <= 1'b0;
`ifdef TICK_GEN_FRAC_EN
      frac_q <= '0;
      acc_q  <= '0;
`endif
    end else begin
      en_q   <= en_d;
      int_q  <= int_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      tog_q  <= tog_d;
`ifdef TICK_GEN_FRAC_EN
      frac_q <= frac_d;
      acc_q  <= acc_d;
`endif
    end
  end

  // Shadow values are only read while pend_q is set, so they need no reset.
  always_ff @(posedge clock) begin
    sh_int_q <= sh_int_d;
`ifdef TICK_GEN_FRAC_EN
    sh_frac_q <= sh_frac_d;
`endif
  end

  assign pend_o   = pend_q;
  assign tick_o   = tick_q;
  assign toggle_o = tog_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator with a valid/ready configuration write port.
// Define TICK_GEN_FRAC_EN to enable the fractional divisor in every channel.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int  CHANNELS   = TICK_CHANNELS,
  parameter int  CNT_WIDTH  = TICK_CNT_W,
  parameter int  FRAC_WIDTH = TICK_FRAC_W,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic                  cfg_en,
  input  logic [CNT_WIDTH-1:0]  cfg_int,
  input  logic [FRAC_WIDTH-1:0] cfg_frac,
  output logic [CHANNELS-1:0]   tick_o,
  output logic [CHANNELS-1:0]   toggle_o
);

  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] wr;

  // An out-of-range channel selects nothing, so the write is accepted and dropped.
  assign cfg_ready = ~|(sel & pend);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign sel[g] = (cfg_chan == CHAN_W'(g));
    assign wr[g]  = cfg_valid && cfg_ready && sel[g];

    tick_chan #(
      .CNT_WIDTH  (CNT_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH)
    ) u_chan (
      .clock    (clock),
      .reset    (reset),
      .wr_i     (wr[g]),
      .en_i     (cfg_en),
      .int_i    (cfg_int),
      .frac_i   (cfg_frac),
      .pend_o   (pend[g]),
      .tick_o   (tick_o[g]),
      .toggle_o (toggle_o[g])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Randomized bench for tick_gen against a schedule-based reference model that tracks
// each channel's absolute next-tick cycle.
module tb_tick_gen;
  import tick_gen_pkg::*;

  localparam int CH = 3;
  localparam int NW = 16;
  localparam int FW = 8;
`ifdef TICK_GEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_chan = '0;
  logic          cfg_en = 1'b0;
  logic [NW-1:0] cfg_int = '0;
  logic [FW-1:0] cfg_frac = '0;
  logic [CH-1:0] tick_o;
  logic [CH-1:0] toggle_o;

  always #5 clock = ~clock;

  tick_gen #(
    .CHANNELS   (CH),
    .CNT_WIDTH  (NW),
    .FRAC_WIDTH (FW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_en    (cfg_en),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .tick_o    (tick_o),
    .toggle_o  (toggle_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: per channel, the configured divisor and the absolute cycle of its next tick.
  longint cyc;
  bit     m_en[CH], m_pend[CH], m_tog[CH], m_tick[CH];
  int     m_n[CH], m_f[CH], m_acc[CH], m_shn[CH], m_shf[CH];
  longint m_next[CH];
  bit     rec1;
  longint t1q[$];

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_en[i] = 0; m_pend[i] = 0; m_tog[i] = 0; m_tick[i] = 0;
      m_n[i] = 0; m_f[i] = 0; m_acc[i] = 0; m_shn[i] = 0; m_shf[i] = 0;
      m_next[i] = 0;
    end
  endtask

  function automatic bit model_ready(input int c);
    return (c < CH) ? !m_pend[c] : 1'b1;
  endfunction

  task automatic model_edge(input bit acc);
    int     c;
    longint s;
    c = int'(cfg_chan);
    for (int i = 0; i < CH; i++) begin
      m_tick[i] = 0;
      if (m_en[i] && cyc == m_next[i]) begin
        m_tick[i] = 1;
        m_tog[i]  = !m_tog[i];
        if (m_pend[i]) begin
          m_n[i] = m_shn[i]; m_f[i] = m_shf[i]; m_acc[i] = 0; m_pend[i] = 0;
          m_next[i] = cyc + m_n[i] + 1;
        end else begin
          s = longint'(m_acc[i]) + m_f[i];
          m_acc[i]  = int'(s % (1 << FW));
          m_next[i] = cyc + m_n[i] + 1 + s / (1 << FW);
        end
      end
    end
    if (acc && c < CH) begin
      if (!m_en[c] || !cfg_en) begin
        m_en[c] = cfg_en; m_n[c] = int'(cfg_int); m_f[c] = FRAC_ON ? int'(cfg_frac) : 0;
        m_acc[c] = 0; m_tog[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
        m_next[c] = cyc + m_n[c] + 1;
      end else begin
        m_shn[c] = int'(cfg_int); m_shf[c] = FRAC_ON ? int'(cfg_frac) : 0; m_pend[c] = 1;
      end
    end
  endtask

  task automatic do_cycle();
    bit acc;
    acc = cfg_valid && model_ready(int'(cfg_chan));
    @(posedge clock);
    cyc++;
    model_edge(acc);
    #1;
    for (int i = 0; i < CH; i++) begin
      check($sformatf("tick%0d@%0d", i, cyc), tick_o[i], m_tick[i]);
      check($sformatf("toggle%0d@%0d", i, cyc), toggle_o[i], m_tog[i]);
    end
    check($sformatf("ready@%0d", cyc), cfg_ready, model_ready(int'(cfg_chan)));
    if (rec1 && tick_o[1]) t1q.push_back(cyc);
  endtask

  task automatic drive(input bit v, input int ch, input tick_cfg_t c);
    cfg_valid = v;
    cfg_chan  = ch[1:0];
    cfg_en    = c.en;
    cfg_int   = c.div_int;
    cfg_frac  = c.div_frac;
  endtask

  task automatic write(input int ch, input bit e, input int n, input int f);
    tick_cfg_t c;
    c.en = e; c.div_int = n[NW-1:0]; c.div_frac = f[FW-1:0];
    drive(1'b1, ch, c);
    do_cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle();
  endtask

  initial begin
    tick_cfg_t rc;
    cyc  = 0;
    rec1 = 0;
    model_reset();

    // Reset held: outputs low, ready high.
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check("rst_tick", tick_o, '0);
      check("rst_toggle", toggle_o, '0);
      check("rst_ready", cfg_ready, 1'b1);
    end
    @(negedge clock);
    reset = 1'b1;
    idle(100);

    // Ch0 N=3, then a reprogram to N=1 while running.
    write(0, 1, 3, 0);
    idle(4);
    write(0, 1, 1, 0);
    idle(10);

    // Ch1 N=2 F=0x80: 16 periods span 56 cycles fractional, 48 integer.
    rec1 = 1;
    write(1, 1, 2, 'h80);
    idle(70);
    rec1 = 0;
    check("ch1_tick_count", (t1q.size() >= 17), 1'b1);
    if (t1q.size() >= 17)
      check("ch1_span16", t1q[16] - t1q[0], FRAC_ON ? 56 : 48);

    // Ch2 N=0 ticks every cycle; disable clears it next cycle.
    write(2, 1, 0, 0);
    idle(5);
    write(2, 0, 0, 0);
    idle(3);

    // Out-of-range channel is accepted and dropped.
    write(3, 1, 5, 'h11);
    idle(3);

    // Package default divisor on ch0.
    write(0, 1, int'(TICK_DEFAULT_INT[0]), 0);
    idle(120);

    // Random traffic, including writes refused while a channel has a pending update.
    for (int k = 0; k < 1500; k++) begin
      rc.en       = ($urandom_range(3) != 0);
      rc.div_int  = NW'($urandom_range(7));
      rc.div_frac = FW'($urandom);
      drive($urandom_range(7) == 0, int'($urandom_range(3)), rc);
      do_cycle();
    end
    cfg_valid = 1'b0;

    // Asynchronous reset mid-period with ch2 ticking every cycle.
    write(2, 1, 0, 0);
    idle(3);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_tick", tick_o, '0);
    check("async_rst_toggle", toggle_o, '0);
    check("async_rst_ready", cfg_ready, 1'b1);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
